mdu_ctrl: RTL
=============

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 48, max cycles in WAIT before abort.
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port op_valid  in  1  EX-stage HI/LO instruction present.
REQ-005 SHALL have port op_type  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, others none.
REQ-006 SHALL have ports rs_data, rt_data  in  32 each  operands.
REQ-007 SHALL have port flush  in  1  pipeline flush/exception, kills in-flight op.
REQ-008 SHALL have port stall_req  out  1  pipeline stall request.
REQ-009 SHALL have ports hi_o, lo_o  out  32 each  architectural HI/LO.
REQ-010 SHALL have ports mdu_start, mdu_annul, mdu_signed  out  1 each; mdu_choose  out  2; mdu_op1, mdu_op2  out  32 each: iterative mul/div unit drive.
REQ-011 SHALL have ports mdu_result  in  64 ({HI,LO} image); mdu_ready  in  1.
REQ-012 SHALL have port err_o  out  1  sticky timeout flag.

Function
REQ-013 SHALL implement states IDLE, WAIT, WRITE, DRAIN.
REQ-014 IDLE: op_valid with MULT/MULTU/DIV/DIVU and flush=0 SHALL latch rs_data/rt_data into mdu_op1/mdu_op2 and go to WAIT.
REQ-015 mdu_choose SHALL be 2'b11 for MULT/MULTU, 2'b01 for DIV/DIVU, 2'b00 in IDLE and DRAIN; mdu_signed SHALL be 1 for MULT/DIV only; choose/signed/operands SHALL stay constant during WAIT and WRITE.
REQ-016 mdu_start SHALL be 1 in WAIT and 0 in every other state.
REQ-017 WAIT: mdu_ready=1 SHALL go to WRITE and capture hi_o<=mdu_result[63:32], lo_o<=mdu_result[31:0] on that edge (divide: HI=remainder, LO=quotient).
REQ-018 WRITE SHALL last exactly one cycle with mdu_start=0, then go to DRAIN.
REQ-019 DRAIN SHALL remain until mdu_ready=0, then return to IDLE; new ops are not accepted in DRAIN.
REQ-020 stall_req SHALL be combinationally 1 when IDLE and a mul/div op is presented (REQ-014), and 1 throughout WAIT; 0 in WRITE, DRAIN, and IDLE otherwise.
REQ-021 A mul/div op presented during DRAIN SHALL see stall_req=1 until accepted from IDLE.
REQ-022 MTHI/MTLO in IDLE with flush=0 SHALL write rs_data to hi_o/lo_o on that edge, no stall, no datapath activity; in DRAIN they SHALL be stalled likewise.
REQ-023 flush=1 in WAIT SHALL drive mdu_annul=1 for that cycle, discard the result (HI/LO unchanged), and go to DRAIN; flush in IDLE SHALL suppress acceptance.
REQ-024 flush in WRITE SHALL be ignored (result already committed).
REQ-025 WAIT counter SHALL clear on entry; reaching TIMEOUT_CYCLES without mdu_ready SHALL assert mdu_annul one cycle, set err_o, leave HI/LO unchanged, go to DRAIN.
REQ-026 mdu_annul SHALL be 0 except in REQ-023/REQ-025 cycles.
REQ-027 Simultaneous mdu_ready and flush in WAIT: flush SHALL win, result discarded.

Reset
REQ-028 rst=0 SHALL asynchronously force state IDLE, hi_o=lo_o=0, mdu_op1=mdu_op2=0, mdu_choose=00, mdu_start=mdu_annul=mdu_signed=0, err_o=0, counter=0; stall_req follows REQ-020.
REQ-029 Reset mid-operation SHALL abandon the op with no HI/LO update.

Configuration
REQ-030 With MDU_DIV0_FAST_EN defined, DIV/DIVU with rt_data=0 in IDLE SHALL complete in that cycle: no stall, no mdu_start, HI/LO unchanged.
REQ-031 Without MDU_DIV0_FAST_EN, divide-by-zero SHALL be issued normally and HI/LO written with whatever mdu_result returns.

Verification
REQ-032 MULT rs=0xFFFFFFFE, rt=3 -> mdu_signed=1, choose=11, stall until ready; hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA.
REQ-033 DIVU rs=100, rt=7 -> choose=01; hi_o=2, lo_o=14; stall_req drops in WRITE cycle.
REQ-034 Flush 5 cycles into DIV -> mdu_annul pulse one cycle, HI/LO unchanged, DRAIN until mdu_ready=0, then IDLE.
REQ-035 MTLO 0x12345678 in IDLE, MULTU 2x2 presented during DRAIN -> lo_o updates without stall; MULTU stalled until IDLE, then hi_o=0, lo_o=4.
REQ-036 mdu_ready held 0 for TIMEOUT_CYCLES=48 -> annul pulse, err_o=1 sticky, state IDLE after drain.
REQ-037 DIV rs=9, rt=0 with MDU_DIV0_FAST_EN -> no stall, mdu_start stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_ctrl.sv
// HI/LO control for an iterative multiply/divide unit: issue, wait, commit, drain.
// Optional MDU_DIV0_FAST_EN: divide by zero retires in IDLE without touching the unit.
module mdu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        stall_req,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        mdu_start,
    output logic        mdu_annul,
    output logic        mdu_signed,
    output logic [1:0]  mdu_choose,
    output logic [31:0] mdu_op1,
    output logic [31:0] mdu_op2,
    input  logic [63:0] mdu_result,
    input  logic        mdu_ready,
    output logic        err_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      op1_q, op1_d, op2_q, op2_d;
    logic [1:0]       choose_q, choose_d;
    logic             signed_q, signed_d;
    logic             err_q, err_d;

    logic mul_op_c, md_op_c, mt_op_c, div0_fast_c, timeout_c;
    logic accept_c, commit_c, mt_wr_c, timeout_hit_c;

    // Instruction decode
    assign mul_op_c = op_valid && (op_type == OP_MULT || op_type == OP_MULTU);
    assign md_op_c  = mul_op_c || (op_valid && (op_type == OP_DIV || op_type == OP_DIVU));
    assign mt_op_c  = op_valid && (op_type == OP_MTHI || op_type == OP_MTLO);

`ifdef MDU_DIV0_FAST_EN
    assign div0_fast_c = op_valid && (op_type == OP_DIV || op_type == OP_DIVU) && (rt_data == 32'd0);
`else
    assign div0_fast_c = 1'b0;
`endif

    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !mdu_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (md_op_c && !flush && !div0_fast_c) state_d = S_WAIT;
            S_WAIT: begin
                if (flush || timeout_c) state_d = S_DRAIN;
                else if (mdu_ready)     state_d = S_WRITE;
            end
            S_WRITE: state_d = S_DRAIN;
            S_DRAIN: if (!mdu_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Per-state outputs and datapath enables; flush beats a same-cycle ready
    always_comb begin
        stall_req     = 1'b0;
        mdu_start     = 1'b0;
        mdu_annul     = 1'b0;
        accept_c      = 1'b0;
        commit_c      = 1'b0;
        mt_wr_c       = 1'b0;
        timeout_hit_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                accept_c  = md_op_c && !flush && !div0_fast_c;
                stall_req = accept_c;
                mt_wr_c   = mt_op_c && !flush;
            end
            S_WAIT: begin
                stall_req     = 1'b1;
                mdu_start     = 1'b1;
                mdu_annul     = flush || timeout_c;
                commit_c      = mdu_ready && !flush;
                timeout_hit_c = timeout_c && !flush;
            end
            S_DRAIN: stall_req = md_op_c || mt_op_c;
            default: ;
        endcase
    end

    // Datapath next values
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        choose_d = choose_q;
        signed_d = signed_q;
        err_d    = err_q | timeout_hit_c;
        cnt_d    = (state_q == S_WAIT) ? cnt_q + CNT_W'(1) : '0;
        if (accept_c) begin
            op1_d    = rs_data;
            op2_d    = rt_data;
            choose_d = mul_op_c ? 2'b11 : 2'b01;
            signed_d = (op_type == OP_MULT) || (op_type == OP_DIV);
        end else if (state_d == S_IDLE || state_d == S_DRAIN) begin
            choose_d = 2'b00;
            signed_d = 1'b0;
        end
        if (commit_c) begin
            hi_d = mdu_result[63:32];
            lo_d = mdu_result[31:0];
        end else if (mt_wr_c) begin
            if (op_type == OP_MTHI) hi_d = rs_data;
            else                    lo_d = rs_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            choose_q <= 2'b00;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            choose_q <= choose_d;
            signed_q <= signed_d;
            err_q    <= err_d;
        end
    end

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign mdu_op1    = op1_q;
    assign mdu_op2    = op2_q;
    assign mdu_choose = choose_q;
    assign mdu_signed = signed_q;
    assign err_o      = err_q;

endmodule
